// File: rtl/fdq_pkg.sv
// Shared types and constants for the fetch/decode queue.
// The optional illegal-opcode trap is enabled with the IFD_ILLEGAL_TRAP_EN macro.
package fdq_pkg;

  localparam int NUM_CLASSES = 7;

  // RV32 major opcodes that map onto a microcode ROM class
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // Bit positions inside the one-hot class vector
  localparam int CLS_R      = 0;
  localparam int CLS_I      = 1;
  localparam int CLS_LOAD   = 2;
  localparam int CLS_STORE  = 3;
  localparam int CLS_BRANCH = 4;
  localparam int CLS_JUMP   = 5;
  localparam int CLS_LUI    = 6;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fdq_state_e;

  // Decoder result: class one-hot plus a 4-bit ROM offset within the class
  typedef struct packed {
    logic [NUM_CLASSES-1:0] cls;
    logic [3:0]             uaddr;
  } fdq_dec_t;

  // Map an instruction word onto its microcode class and ROM offset
  function automatic fdq_dec_t fdq_decode(input logic [31:0] instr);
    fdq_dec_t d;
    d.cls   = '0;
    d.uaddr = '0;
    case (instr[6:0])
      OPC_R: begin
        d.cls[CLS_R] = 1'b1;
        d.uaddr      = {instr[30], instr[14:12]};
      end
      OPC_I: begin
        d.cls[CLS_I] = 1'b1;
        d.uaddr      = {1'b0, instr[14:12]};
      end
      OPC_LOAD: begin
        d.cls[CLS_LOAD] = 1'b1;
        d.uaddr         = {1'b0, instr[14:12]};
      end
      OPC_STORE: begin
        d.cls[CLS_STORE] = 1'b1;
        d.uaddr          = {1'b0, instr[14:12]};
      end
      OPC_BRANCH: begin
        d.cls[CLS_BRANCH] = 1'b1;
        d.uaddr           = {1'b0, instr[14:12]};
      end
      OPC_JAL: begin
        d.cls[CLS_JUMP] = 1'b1;
        d.uaddr         = 4'd0;
      end
      OPC_JALR: begin
        d.cls[CLS_JUMP] = 1'b1;
        d.uaddr         = 4'd1;
      end
      OPC_LUI: begin
        d.cls[CLS_LUI] = 1'b1;
        d.uaddr        = 4'd0;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fdq_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two.
// Head is read combinationally from storage, so a word pushed in one cycle
// is visible at the head the next cycle.
module fdq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             pop_ok;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign pop_ok = pop && !empty;
  assign head   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // The credit scheme upstream should make overflow unreachable
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && full && !flush));

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch/decode front end: PC, credit-limited imem requests, response queue
// and head decode into a one-hot microcode class plus ROM address.
// Optional feature: define IFD_ILLEGAL_TRAP_EN to trap unclassified opcodes
// (adds the illegal_instr port and a HALT state).
module fetch_decode_queue
  import fdq_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               FQ_DEPTH = 4,
  parameter int               UADDR_W  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          imem_req_valid,
  output logic [XLEN-1:0]               imem_req_addr,
  input  logic                          imem_req_ready,
  input  logic                          imem_rsp_valid,
  input  logic [31:0]                   imem_rsp_data,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          dec_valid,
  input  logic                          dec_ready,
  output logic [NUM_CLASSES-1:0]        dec_class,
  output logic [UADDR_W-1:0]            dec_uaddr,
  output logic [31:0]                   dec_instr,
  output logic [XLEN-1:0]               dec_pc,
  output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
`ifdef IFD_ILLEGAL_TRAP_EN
  ,
  output logic                          illegal_instr
`endif
);

  localparam int CNT_W = $clog2(FQ_DEPTH+1);

  logic [XLEN-1:0]  pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] out_nxt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] tag_count;
  logic [CNT_W:0]   inflight;
  logic             run;
  logic             accept;
  logic             rsp_push;
  logic             pop;
  logic [XLEN-1:0]  tag_head;
  logic [31:0]      head_instr;
  logic [XLEN-1:0]  head_pc;
  fdq_dec_t         head_dec;

  // Credits: every accepted request must have a queue slot when it returns
  assign inflight       = {1'b0, outstanding} + {1'b0, fq_count};
  assign imem_req_valid = !reset && run && (inflight < (CNT_W+1)'(FQ_DEPTH));
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Responses in a redirect cycle or while draining old requests are discarded
  assign rsp_push = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign dec_valid = (fq_count != '0);
  assign pop       = dec_valid && dec_ready;

  // Outstanding count after this cycle's accept/response
  always_comb begin
    out_nxt = outstanding;
    case ({accept, imem_rsp_valid})
      2'b10:   out_nxt = outstanding + 1'b1;
      2'b01:   out_nxt = outstanding - 1'b1;
      default: ;
    endcase
  end

  // PC, in-flight request count and drop budget
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect_valid) begin
        pc       <= {redirect_pc[XLEN-1:2], 2'b00};
        // every request still in flight after this cycle belongs to the old path
        drop_cnt <= out_nxt;
      end else begin
        if (accept) pc <= pc + XLEN'(4);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // Request-address FIFO: supplies the PC tag of each kept response
  fdq_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept && !redirect_valid),
    .push_data (pc),
    .pop       (rsp_push),
    .flush     (redirect_valid),
    .head      (tag_head),
    .count     (tag_count)
  );

  // Instruction queue: {instruction, pc}
  fdq_fifo #(
    .WIDTH (32 + XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_push),
    .push_data ({imem_rsp_data, tag_head}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      ({head_instr, head_pc}),
    .count     (fq_count)
  );

  // Tags for kept responses can never outnumber requests in flight
  a_tag_bound: assert property (@(posedge clk) disable iff (reset)
    tag_count <= outstanding);

  // Head decode; outputs held at zero while the queue is empty
  always_comb begin
    head_dec  = fdq_decode(head_instr);
    dec_class = '0;
    dec_uaddr = '0;
    dec_instr = '0;
    dec_pc    = '0;
    if (dec_valid) begin
      dec_class = head_dec.cls;
      dec_uaddr = UADDR_W'(head_dec.uaddr);
      dec_instr = head_instr;
      dec_pc    = head_pc;
    end
  end

`ifdef IFD_ILLEGAL_TRAP_EN
  fdq_state_e state;
  fdq_state_e state_nxt;

  // Trap state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Consuming an unclassified head halts fetch until the next redirect
  always_comb begin
    state_nxt     = state;
    run           = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      RUN: begin
        run           = 1'b1;
        illegal_instr = dec_valid && (dec_class == '0);
        if (!redirect_valid && pop && (dec_class == '0)) state_nxt = HALT;
      end
      HALT: begin
        illegal_instr = 1'b1;
        if (redirect_valid) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end
`else
  assign run = 1'b1;
`endif

endmodule
